// File: rtl/cronometro_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cronometro_pkg: shared types, digit map, limits and segment codes           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int N_DIGITS = 8;
  localparam int D_CC0 = 0;
  localparam int D_CC1 = 1;
  localparam int D_SS0 = 2;
  localparam int D_SS1 = 3;
  localparam int D_MM0 = 4;
  localparam int D_MM1 = 5;
  localparam int D_HH0 = 6;
  localparam int D_HH1 = 7;

  localparam int LIM_CC = 99;
  localparam int LIM_SS = 59;
  localparam int LIM_MM = 59;
  localparam int LIM_HH = 99;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Even digits are units (limit % 10), odd digits are tens (limit / 10).
  function automatic logic [3:0] digit_max(input int d);
    int lim;
    case (d)
      D_CC0, D_CC1: lim = LIM_CC;
      D_SS0, D_SS1: lim = LIM_SS;
      D_MM0, D_MM1: lim = LIM_MM;
      default:      lim = LIM_HH;
    endcase
    return ((d % 2) == 0) ? 4'(lim % 10) : 4'(lim / 10);
  endfunction

  // Returns {carry_out, next_digits}; carry_out flags the full rollover.
  function automatic logic [32:0] bcd_increment(input logic [31:0] cur);
    logic [31:0] nxt;
    logic        carry;
    nxt   = cur;
    carry = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (carry) begin
        if (cur[4*d +: 4] == digit_max(d)) begin
          nxt[4*d +: 4] = 4'd0;
        end else begin
          nxt[4*d +: 4] = cur[4*d +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, nxt};
  endfunction

endpackage : cronometro_pkg
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_dec: BCD digit to active-low 7-segment code {g,f,e,d,c,b,a}            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seg7_dec
  import cronometro_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule : seg7_dec
`default_nettype wire

// File: rtl/cronometro_hx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cronometro_hx: HH:MM:SS.CC stopwatch with start/stop/clear and 8x7 segments |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cronometro_hx
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [55:0] hx,
  output logic [31:0] bcd,
  output logic        running,
  output logic        wrap
);

  localparam int             PW          = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0]  c_PRESC_MAX = PW'(TICK_DIV - 1);

  logic          r_start_q;
  logic          r_clear_q;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_bcd;
  logic          r_wrap;
  logic [55:0]   r_hx;
  logic [55:0]   w_seg;
  logic [32:0]   w_inc;
  logic          w_start_edge;
  logic          w_clear_edge;
  logic          w_tick;
  logic          w_running;
  logic          w_presc_clr;
  logic          w_presc_run;
  logic          w_digits_clr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_start_q <= btn_start_stop;
      r_clear_q <= btn_clear;
    end
  end

  assign w_start_edge = btn_start_stop & ~r_start_q;
  assign w_clear_edge = btn_clear & ~r_clear_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In PAUSE a clear edge beats a simultaneous start edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_nxt = RUN;
      RUN:     if (w_start_edge) w_state_nxt = PAUSE;
      PAUSE: begin
        if (w_clear_edge)      w_state_nxt = IDLE;
        else if (w_start_edge) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_running    = (r_state == RUN);
    w_digits_clr = (r_state == PAUSE) && w_clear_edge;
    w_presc_clr  = ((r_state == IDLE) && w_start_edge) || w_digits_clr;
    w_presc_run  = (r_state == RUN) && !w_start_edge;
  end

  assign w_tick = (r_state == RUN) && (r_presc == c_PRESC_MAX);

  // A pausing edge freezes the prescaler unless it coincides with a tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_presc_clr || w_tick) begin
      r_presc <= '0;
    end else if (w_presc_run) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_inc = bcd_increment(r_bcd);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick & w_inc[32];
      if (w_digits_clr) begin
        r_bcd <= '0;
      end else if (w_tick) begin
        r_bcd <= w_inc[31:0];
      end
    end
  end

  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dec
    seg7_dec u_dec (
      .i_bcd (r_bcd[4*d +: 4]),
      .o_seg (w_seg[7*d +: 7])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hx <= {N_DIGITS{SEG_0}};
    end else begin
      r_hx <= w_seg;
    end
  end

  assign hx      = r_hx;
  assign bcd     = r_bcd;
  assign running = w_running;
  assign wrap    = r_wrap;

endmodule : cronometro_hx
`default_nettype wire

// File: tb/tb_cronometro_hx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cronometro_hx: directed scoreboard bench for the stopwatch, TICK_DIV=4   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cronometro_hx;

  localparam int          TICK_DIV = 4;
  localparam logic [55:0] HX_ZERO  = {8{7'h40}};

  localparam int K_BCD  = 0;
  localparam int K_RUN  = 1;
  localparam int K_WRAP = 2;
  localparam int K_HX   = 3;

  logic        clock;
  logic        reset;
  logic        btn_start_stop;
  logic        btn_clear;
  logic [55:0] hx;
  logic [31:0] bcd;
  logic        running;
  logic        wrap;

  typedef struct {
    string       tag;
    int          kind;
    logic [55:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  cronometro_hx #(.TICK_DIV(TICK_DIV)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .hx             (hx),
    .bcd            (bcd),
    .running        (running),
    .wrap           (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input int kind, input logic [55:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [55:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_BCD:   obs = {24'd0, bcd};
        K_RUN:   obs = {55'd0, running};
        K_WRAP:  obs = {55'd0, wrap};
        default: obs = hx;
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    logic [55:0] hx_exp;

    reset          = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;

    // Reset held three cycles
    cyc(3);
    expect_out("rst_bcd",  K_BCD,  56'd0);
    expect_out("rst_run",  K_RUN,  56'd0);
    expect_out("rst_wrap", K_WRAP, 56'd0);
    expect_out("rst_hx",   K_HX,   HX_ZERO);
    check_now();
    reset = 1'b0;
    cyc(1);

    // Start, then 400 RUN cycles = 100 ticks = 00:00:01.00
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    expect_out("start_run", K_RUN, 56'd1);
    check_now();
    cyc(400);
    expect_out("one_sec_bcd", K_BCD, 56'h0000_0100);
    check_now();
    cyc(1);
    hx_exp         = HX_ZERO;
    hx_exp[20:14]  = 7'h79;
    expect_out("one_sec_hx", K_HX, hx_exp);
    check_now();

    // Pause with prescaler at 2, hold, resume: tick 2 cycles later
    cyc(1);
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    expect_out("pause_run", K_RUN, 56'd0);
    check_now();
    cyc(100);
    expect_out("pause_frozen", K_BCD, 56'h0000_0100);
    check_now();
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    cyc(1);
    expect_out("resume_no_tick_yet", K_BCD, 56'h0000_0100);
    check_now();
    cyc(1);
    expect_out("resume_tick", K_BCD, 56'h0000_0101);
    check_now();

    // Clear ignored in RUN; simultaneous clear+start in PAUSE clears
    btn_clear = 1'b1;
    cyc(1);
    btn_clear = 1'b0;
    expect_out("clr_in_run_bcd", K_BCD, 56'h0000_0101);
    expect_out("clr_in_run_run", K_RUN, 56'd1);
    check_now();
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    expect_out("pause2_run", K_RUN, 56'd0);
    check_now();
    cyc(1);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    expect_out("clear_bcd", K_BCD, 56'd0);
    expect_out("clear_run", K_RUN, 56'd0);
    check_now();
    cyc(1);
    expect_out("clear_hx", K_HX, HX_ZERO);
    check_now();
    cyc(5);
    expect_out("idle_stays", K_RUN, 56'd0);
    check_now();

    // Deposit 99:59:59.99 right after entering RUN; first tick wraps
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    dut.r_bcd = 32'h9959_5999;
    cyc(3);
    expect_out("pre_wrap_bcd",  K_BCD,  56'h9959_5999);
    expect_out("pre_wrap_wrap", K_WRAP, 56'd0);
    check_now();
    cyc(1);
    expect_out("wrap_bcd",  K_BCD,  56'd0);
    expect_out("wrap_wrap", K_WRAP, 56'd1);
    expect_out("wrap_run",  K_RUN,  56'd1);
    check_now();
    cyc(1);
    expect_out("wrap_pulse_end", K_WRAP, 56'd0);
    expect_out("wrap_still_run", K_RUN,  56'd1);
    check_now();

    // Held button: one toggle only
    btn_start_stop = 1'b1;
    cyc(20);
    expect_out("held_single_toggle", K_RUN, 56'd0);
    check_now();
    btn_start_stop = 1'b0;
    cyc(1);
    btn_start_stop = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0;
    expect_out("rerun", K_RUN, 56'd1);
    check_now();
    cyc(10);
    expect_out("rerun_bcd", K_BCD, 56'h0000_0002);
    check_now();

    // Reset mid-RUN
    reset = 1'b1;
    cyc(1);
    expect_out("midrst_bcd",  K_BCD,  56'd0);
    expect_out("midrst_run",  K_RUN,  56'd0);
    expect_out("midrst_wrap", K_WRAP, 56'd0);
    expect_out("midrst_hx",   K_HX,   HX_ZERO);
    check_now();
    reset = 1'b0;
    cyc(2);
    expect_out("post_rst_idle", K_RUN, 56'd0);
    expect_out("post_rst_bcd",  K_BCD, 56'd0);
    check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cronometro_hx
`default_nettype wire
